// File: rtl/nibble_add_seq_if.sv
// Handshake bundle for nibble_add_seq.
//   request side : in_valid, in_ready, op_sub, a, b
//   result side  : out_valid, out_ready, sum, cout, ovf
// master = requester/consumer (e.g. a testbench), slave = the adder block.
interface nibble_add_seq_if #(
  parameter int unsigned NIB = 4
);
  localparam int unsigned W = 4 * NIB;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_add_seq.sv
// Sequential W-bit adder/subtractor (W = 4*NIB) built from a single 4-bit
// carry-lookahead slice that is reused once per nibble, LSB nibble first.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - nibble_add_seq_if.slave: request (in_valid/in_ready/op_sub/a/b)
//          and result (out_valid/out_ready/sum/cout/ovf) handshakes
// A request is accepted in IDLE, takes NIB cycles in RUN, and the result is
// held in DONE until out_ready.
module nibble_add_seq #(
  parameter int unsigned NIB = 4
) (
  input logic            clk,
  input logic            rst,
  nibble_add_seq_if.slave bus
);
  localparam int unsigned W    = 4 * NIB;
  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;     // already inverted for subtract
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [3:0]      slice_x, slice_y, slice_s;
  logic            slice_co;
  logic            last_nib;

  // 4-bit carry-lookahead slice: returns {cout, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] p, g;
    logic [4:0] c;
    p    = x ^ y;
    g    = x & y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // The only adder in the block; operands selected by the nibble index.
  always_comb begin
    slice_x              = a_q[{idx_q, 2'b00} +: 4];
    slice_y              = b_q[{idx_q, 2'b00} +: 4];
    {slice_co, slice_s}  = cla4(slice_x, slice_y, carry_q);
  end

  assign last_nib = (idx_q == IdxW'(NIB - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.op_sub ? ~bus.b : bus.b;
          carry_d = bus.op_sub;  // +1 of the two's-complement negate
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        work_d[{idx_q, 2'b00} +: 4] = slice_s;
        carry_d                     = slice_co;
        idx_d                       = idx_q + 1'b1;
        if (last_nib) begin
          state_d = StDone;
          sum_d   = work_d;
          cout_d  = slice_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (work_d[W-1] != a_q[W-1]);
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // in_ready gated by rst so it drops the instant reset is asserted.
  assign bus.in_ready  = (state_q == StIdle) & ~rst;
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule
